// File: rtl/demux2_buffered.sv
// demux2_buffered: registered 1-to-2 demultiplexer with a DEPTH-entry FIFO per
// output, so a stalled consumer on one port never blocks the other port.
// Optional build macro DEMUX2_CNT_EN adds 16-bit popped-word counters
// (b_count, c_count).

// Per-port FIFO: storage, pointers and occupancy for one output.
module demux2_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             valid,
  output logic             full
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [PW-1:0]               wr_ptr, rd_ptr;
  logic [CW-1:0]               count;

  // Occupancy is registered, so full (and thus in_ready) only moves on clock edges.
  assign full  = (count == CW'(DEPTH));
  assign valid = (count != '0);
  assign rdata = mem[rd_ptr];

  // Storage write, pointer advance (natural wrap, DEPTH is a power of two) and count update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

module demux2_buffered #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] b_data,
  output logic             b_valid,
  input  logic             b_ready,
  output logic [WIDTH-1:0] c_data,
  output logic             c_valid,
  input  logic             c_ready
`ifdef DEMUX2_CNT_EN
  ,
  output logic [15:0]      b_count,
  output logic [15:0]      c_count
`endif
);
  // Index 0 is port B, index 1 is port C (matches in_sel encoding).
  logic [1:0]            full, valid, ready, push, pop;
  logic [1:0][WIDTH-1:0] rdata;

  // Ready depends only on the selected FIFO's registered fullness, never on output readies.
  assign in_ready = in_sel ? !full[1] : !full[0];
  assign push[0]  = in_valid && in_ready && !in_sel;
  assign push[1]  = in_valid && in_ready &&  in_sel;
  assign ready    = {c_ready, b_ready};
  assign pop      = valid & ready;

  for (genvar i = 0; i < 2; i++) begin : g_port
    demux2_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push[i]),
      .wdata (in_data),
      .pop   (pop[i]),
      .rdata (rdata[i]),
      .valid (valid[i]),
      .full  (full[i])
    );
  end

  assign b_data  = rdata[0];
  assign b_valid = valid[0];
  assign c_data  = rdata[1];
  assign c_valid = valid[1];

`ifdef DEMUX2_CNT_EN
  logic [1:0][15:0] pop_cnt;

  // Free-running popped-word counters, wrapping at 16 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pop_cnt <= '0;
    end else begin
      for (int i = 0; i < 2; i++)
        if (pop[i]) pop_cnt[i] <= pop_cnt[i] + 16'd1;
    end
  end

  assign b_count = pop_cnt[0];
  assign c_count = pop_cnt[1];
`endif
endmodule

// File: tb/tb_demux2_buffered.sv
// Self-checking bench for demux2_buffered: table vectors, directed corner
// sequences and random traffic against a queue-based reference model.
module tb_demux2_buffered;
  localparam int WIDTH = 32;
  localparam int DEPTH = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [WIDTH-1:0] in_data;
  logic             in_sel, in_valid, in_ready;
  logic [WIDTH-1:0] b_data, c_data;
  logic             b_valid, b_ready, c_valid, c_ready;
`ifdef DEMUX2_CNT_EN
  logic [15:0]      b_count, c_count;
`endif

  demux2_buffered #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_sel(in_sel),
    .in_valid(in_valid), .in_ready(in_ready), .b_data(b_data),
    .b_valid(b_valid), .b_ready(b_ready), .c_data(c_data),
    .c_valid(c_valid), .c_ready(c_ready)
`ifdef DEMUX2_CNT_EN
    , .b_count(b_count), .c_count(c_count)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model: one bounded queue per port plus popped-word tallies
  logic [31:0] qb[$];
  logic [31:0] qc[$];
  int pops_b = 0, pops_c = 0;
  logic last_acc;
  logic [31:0] delivered_b[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Drive one cycle, compare against the model, clock it, update the model.
  task automatic cycle(input logic s, input logic v, input logic [31:0] d,
                       input logic br, input logic cr);
    logic exp_rdy;
    in_sel = s; in_valid = v; in_data = d; b_ready = br; c_ready = cr;
    #1;
    exp_rdy = s ? (qc.size() < DEPTH) : (qb.size() < DEPTH);
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    chk("b_valid", 32'(b_valid), 32'(qb.size() != 0));
    if (qb.size() != 0) chk("b_data", b_data, qb[0]);
    chk("c_valid", 32'(c_valid), 32'(qc.size() != 0));
    if (qc.size() != 0) chk("c_data", c_data, qc[0]);
`ifdef DEMUX2_CNT_EN
    chk("b_count", 32'(b_count), 32'(pops_b[15:0]));
    chk("c_count", 32'(c_count), 32'(pops_c[15:0]));
`endif
    @(posedge clk);
    if (qb.size() != 0 && br) begin delivered_b.push_back(qb.pop_front()); pops_b++; end
    if (qc.size() != 0 && cr) begin void'(qc.pop_front()); pops_c++; end
    last_acc = v && exp_rdy;
    if (last_acc) begin
      if (s) qc.push_back(d); else qb.push_back(d);
    end
    #1;
  endtask

  task automatic model_reset();
    qb.delete(); qc.delete(); pops_b = 0; pops_c = 0;
  endtask

  typedef struct {
    logic        sel, vld;
    logic [31:0] data;
    logic        br, cr;
    logic        e_rdy, e_bv;
    logic [31:0] e_bd;
    logic        e_cv;
    logic [31:0] e_cd;
  } vec_t;

  vec_t tbl[5];

  initial begin
    // steering vectors: outputs expected just before each edge, both consumers ready
    tbl[0] = '{1'b0, 1'b1, 32'h1111_1111, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0};
    tbl[1] = '{1'b1, 1'b1, 32'h2222_2222, 1'b1, 1'b1, 1'b1, 1'b1, 32'h1111_1111, 1'b0, 32'h0};
    tbl[2] = '{1'b0, 1'b1, 32'h3333_3333, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h2222_2222};
    tbl[3] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 1'b1, 1'b1, 32'h3333_3333, 1'b0, 32'h0};
    tbl[4] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0};

    // ---- reset: hold low while toggling inputs
    rst_n = 1'b0; in_sel = 0; in_valid = 0; in_data = 0; b_ready = 0; c_ready = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; in_sel = i[0]; in_data = 32'hDEAD_0000 + 32'(i);
      b_ready = i[1]; c_ready = ~i[1];
      #1;
      chk("rst b_valid", 32'(b_valid), 32'd0);
      chk("rst c_valid", 32'(c_valid), 32'd0);
      chk("rst b_data", b_data, 32'd0);
      chk("rst c_data", c_data, 32'd0);
      chk("rst in_ready", 32'(in_ready), 32'd1);
    end
`ifdef DEMUX2_CNT_EN
    chk("rst b_count", 32'(b_count), 32'd0);
    chk("rst c_count", 32'(c_count), 32'd0);
`endif
    model_reset();
    rst_n = 1'b1;
    cycle(1'b0, 1'b1, 32'h0000_00AA, 1'b0, 1'b0);
    chk("first push b_valid", 32'(b_valid), 32'd1);
    chk("first push b_data", b_data, 32'h0000_00AA);
    cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);

    // ---- steering table
    foreach (tbl[i]) begin
      in_sel = tbl[i].sel; in_valid = tbl[i].vld; in_data = tbl[i].data;
      b_ready = tbl[i].br; c_ready = tbl[i].cr;
      #1;
      chk($sformatf("tbl%0d in_ready", i), 32'(in_ready), 32'(tbl[i].e_rdy));
      chk($sformatf("tbl%0d b_valid", i), 32'(b_valid), 32'(tbl[i].e_bv));
      if (tbl[i].e_bv) chk($sformatf("tbl%0d b_data", i), b_data, tbl[i].e_bd);
      chk($sformatf("tbl%0d c_valid", i), 32'(c_valid), 32'(tbl[i].e_cv));
      if (tbl[i].e_cv) chk($sformatf("tbl%0d c_data", i), c_data, tbl[i].e_cd);
      cycle(tbl[i].sel, tbl[i].vld, tbl[i].data, tbl[i].br, tbl[i].cr);
    end

    // ---- backpressure isolation: B stalled and filled
    cycle(1'b0, 1'b1, 32'hB000_0001, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 32'hB000_0002, 1'b0, 1'b0);
    in_sel = 1'b0; in_valid = 1'b1; in_data = 32'hB000_0003; #1;
    chk("B full in_ready sel0", 32'(in_ready), 32'd0);
    in_sel = 1'b1; #1;
    chk("B full in_ready sel1", 32'(in_ready), 32'd1);
    cycle(1'b1, 1'b1, 32'hC0DE_0001, 1'b0, 1'b1);
    chk("C delivered valid", 32'(c_valid), 32'd1);
    chk("C delivered data", c_data, 32'hC0DE_0001);
    cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
    chk("C drained", 32'(c_valid), 32'd0);

    // ---- full with simultaneous pop: word refused now, accepted next cycle
    cycle(1'b0, 1'b1, 32'hB000_0003, 1'b1, 1'b0);
    chk("full+pop refused", 32'(last_acc), 32'd0);
    chk("one left b_data", b_data, 32'hB000_0002);
    cycle(1'b0, 1'b1, 32'hB000_0003, 1'b0, 1'b0);
    chk("accepted next cycle", 32'(last_acc), 32'd1);
    cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    chk("B empty", 32'(b_valid), 32'd0);

    // ---- wrap-around: 10 words with b_ready toggling, bounded cycle budget
    begin
      int sent = 0, cyc = 0;
      delivered_b.delete();
      while ((sent < 10 || qb.size() != 0) && cyc < 100) begin
        cycle(1'b0, sent < 10, 32'(sent), cyc[0], 1'b0);
        if (last_acc) sent++;
        cyc++;
      end
      chk("wrap delivered count", 32'(delivered_b.size()), 32'd10);
      for (int i = 0; i < 10 && i < delivered_b.size(); i++)
        chk("wrap order", delivered_b[i], 32'(i));
    end

    // ---- random traffic
    for (int i = 0; i < 400; i++)
      cycle(1'($urandom_range(1)), ($urandom_range(3) != 0), $urandom(),
            ($urandom_range(3) != 0), ($urandom_range(2) != 0));
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);

    // ---- mid-run reset with buffered data, then counters
    cycle(1'b1, 1'b1, 32'h5555_0001, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 32'h5555_0002, 1'b0, 1'b0);
    rst_n = 1'b0; #1;
    chk("async rst b_valid", 32'(b_valid), 32'd0);
    chk("async rst c_valid", 32'(c_valid), 32'd0);
    model_reset();
    @(posedge clk); #1; rst_n = 1'b1;
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 32'hA000_0000 + 32'(i), 1'b1, 1'b1);
    cycle(1'b1, 1'b1, 32'hCCCC_0001, 1'b1, 1'b1);
    cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    chk("model pops_b", 32'(pops_b), 32'd3);
    chk("model pops_c", 32'(pops_c), 32'd1);
`ifdef DEMUX2_CNT_EN
    chk("b_count=3", 32'(b_count), 32'd3);
    chk("c_count=1", 32'(c_count), 32'd1);
`endif
    cycle(1'b1, 1'b1, 32'hCCCC_0002, 1'b0, 1'b0);
    chk("C holds word", 32'(c_valid), 32'd1);
    rst_n = 1'b0; #1;
    chk("rst2 c_valid", 32'(c_valid), 32'd0);
    chk("rst2 c_data", c_data, 32'd0);
`ifdef DEMUX2_CNT_EN
    chk("rst2 b_count", 32'(b_count), 32'd0);
    chk("rst2 c_count", 32'(c_count), 32'd0);
`endif
    model_reset();
    @(posedge clk); #1; rst_n = 1'b1;
    cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
